fifo_burst_drain: RTL and testbench

//  Drains a ready/valid FIFO read port (deq side of fifo/fifo_af) and turns the stream into

---
 rtl/fifo_burst_drain_if.sv | 37 +++
 rtl/fifo_burst_drain.sv | 147 ++++++++++++++
 tb/tb_fifo_burst_drain.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_drain_if.sv
// Bus bundle for fifo_burst_drain: FIFO read port, burst request channel and write data channel.
// Handshake: a beat transfers on a rising clk edge where valid && ready; once valid is high the
// sender keeps its payload stable until that edge, and valid never depends on ready.
interface fifo_burst_drain_if #(
    parameter int WIDTH    = 32,
    parameter int AWIDTH   = 32,
    parameter int LOGDEPTH = 3,
    parameter int LOGBURST = 2
);
    // FIFO read (deq) side
    logic                in_valid;
    logic [WIDTH-1:0]    in_data;
    logic                in_ready;
    logic [LOGDEPTH:0]   in_count;

    // burst request channel
    logic                req_valid;
    logic [AWIDTH-1:0]   req_addr;
    logic [LOGBURST:0]   req_len;
    logic                req_ready;

    // write data channel
    logic                wr_valid;
    logic [WIDTH-1:0]    wr_data;
    logic                wr_last;
    logic                wr_ready;

    modport master (
        input  in_valid, in_data, in_count, req_ready, wr_ready,
        output in_ready, req_valid, req_addr, req_len, wr_valid, wr_data, wr_last
    );

    modport slave (
        output in_valid, in_data, in_count, req_ready, wr_ready,
        input  in_ready, req_valid, req_addr, req_len, wr_valid, wr_data, wr_last
    );
endinterface

// File: rtl/fifo_burst_drain.sv
// Drains a FIFO read port into length-prefixed write bursts: one (addr,len) request beat, then
// len data beats passed straight through from the FIFO head with wr_last on the final one.
module fifo_burst_drain #(
    parameter int WIDTH    = 32,
    parameter int AWIDTH   = 32,
    parameter int LOGDEPTH = 3,
    parameter int LOGBURST = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_burst_drain_if.master bus,
    input  logic              flush,
    input  logic              cfg_load,
    input  logic [AWIDTH-1:0] cfg_base,
    output logic              busy,
    output logic [1:0]        state_dbg
);
    localparam int MAXB = 1 << LOGBURST;
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]       TIMER_MAX  = TW'(TIMEOUT - 1);
    localparam logic [LOGDEPTH:0]   MAXB_CNT   = (LOGDEPTH + 1)'(MAXB);
    localparam logic [LOGBURST:0]   MAXB_LEN   = (LOGBURST + 1)'(MAXB);
    localparam logic [AWIDTH-1:0]   BEAT_BYTES = AWIDTH'(WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] req_addr_q;
    logic [LOGBURST:0] len_q;
    logic [LOGBURST:0] beat_q;
    logic [TW-1:0]     timer_q;
    logic              flush_pend_q;

    logic              has_data;
    logic              full_burst;
    logic              trigger;
    logic              req_fire;
    logic              wr_fire;
    logic              last_beat;
    logic [LOGBURST:0] burst_len;

    assign has_data   = (bus.in_count != '0);
    assign full_burst = (bus.in_count >= MAXB_CNT);
    // cfg_load wins over a trigger in the same cycle so the new base is used by the next burst
    assign trigger    = (state == IDLE) && !cfg_load &&
                        (full_burst || (has_data && ((timer_q == TIMER_MAX) || flush || flush_pend_q)));
    assign burst_len  = full_burst ? MAXB_LEN : bus.in_count[LOGBURST:0];
    assign req_fire   = bus.req_valid && bus.req_ready;
    assign wr_fire    = bus.wr_valid && bus.wr_ready;
    assign last_beat  = (beat_q == (len_q - (LOGBURST + 1)'(1)));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (trigger) state_next = REQ;
            REQ:  if (req_fire) state_next = DATA;
            DATA: if (wr_fire && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // outputs: DATA is a zero-latency pass-through of the FIFO head, so the FIFO only pops on wr fire
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.req_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.wr_last   = 1'b0;
        case (state)
            REQ: begin
                bus.req_valid = 1'b1;
            end
            DATA: begin
                bus.wr_valid = bus.in_valid;
                bus.wr_data  = bus.in_data;
                bus.in_ready = bus.wr_ready;
                bus.wr_last  = last_beat;
            end
            default: ;
        endcase
    end

    assign bus.req_addr = req_addr_q;
    assign bus.req_len  = len_q;
    assign busy         = (state != IDLE);
    assign state_dbg    = state;

    // datapath: address counter, burst latch, beat counter, idle timer, pending flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            req_addr_q   <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            timer_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (cfg_load) begin
                    addr_q <= cfg_base;
                end
                if (trigger) begin
                    len_q        <= burst_len;
                    req_addr_q   <= addr_q;
                    timer_q      <= '0;
                    flush_pend_q <= 1'b0;
                end else begin
                    if (!has_data) begin
                        timer_q <= '0;
                    end else if (!full_burst && (timer_q != TIMER_MAX)) begin
                        timer_q <= timer_q + TW'(1);
                    end
                    // a flush that cannot be served now is remembered for the next data
                    if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                end
            end
            if (req_fire) begin
                beat_q <= '0;
            end
            if (state == DATA && wr_fire) begin
                beat_q <= beat_q + (LOGBURST + 1)'(1);
                if (last_beat) begin
                    addr_q <= addr_q + (AWIDTH'(len_q) * BEAT_BYTES);
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_burst_drain.sv
// Directed bench for fifo_burst_drain: a queue stands in for the upstream FIFO and every
// expected address, length and data word is a hand-computed constant.
module tb_fifo_burst_drain;
  localparam int WIDTH    = 32;
  localparam int AWIDTH   = 32;
  localparam int LOGDEPTH = 3;
  localparam int LOGBURST = 2;
  localparam int TIMEOUT  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              cfg_load;
  logic [AWIDTH-1:0] cfg_base;
  logic              busy;
  logic [1:0]        state_dbg;

  fifo_burst_drain_if #(
    .WIDTH(WIDTH), .AWIDTH(AWIDTH), .LOGDEPTH(LOGDEPTH), .LOGBURST(LOGBURST)
  ) bus ();

  fifo_burst_drain #(
    .WIDTH(WIDTH), .AWIDTH(AWIDTH), .LOGDEPTH(LOGDEPTH), .LOGBURST(LOGBURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .flush     (flush),
    .cfg_load  (cfg_load),
    .cfg_base  (cfg_base),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [WIDTH-1:0] fifo_q[$];
  int n_checks = 0;
  int n_errors = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_fifo();
    bus.in_valid = (fifo_q.size() > 0);
    bus.in_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    bus.in_count = (LOGDEPTH + 1)'(fifo_q.size());
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    fifo_q.push_back(d);
    drive_fifo();
  endtask

  task automatic tick();
    logic fire;
    fire = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
    if (fire) void'(fifo_q.pop_front());
    drive_fifo();
    #1;
  endtask

  task automatic wait_req(input logic [AWIDTH-1:0] exp_addr, input int exp_len, input string tag);
    int n;
    n = 0;
    while (!bus.req_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " req_valid"}, bus.req_valid, 1);
    chk({tag, " req_addr"}, bus.req_addr, exp_addr);
    chk({tag, " req_len"}, bus.req_len, exp_len);
    chk({tag, " in_ready in REQ"}, bus.in_ready, 0);
  endtask

  // scoreboard-style beat collector: data must be base+i in order, last only on beat len-1
  task automatic collect(input int n_beats, input int len, input logic [WIDTH-1:0] base,
                         input bit toggle, input string tag);
    int i;
    int step;
    i = 0;
    step = 0;
    while (i < n_beats && step < 60) begin
      if (toggle) begin
        bus.wr_ready = step[0];
        #1;
      end
      chk({tag, " in_ready=wr_ready"}, bus.in_ready, bus.wr_ready);
      chk({tag, " wr_valid=in_valid"}, bus.wr_valid, bus.in_valid);
      if (bus.wr_valid && bus.wr_ready) begin
        chk({tag, " wr_data"}, bus.wr_data, base + WIDTH'(i));
        chk({tag, " wr_last"}, bus.wr_last, (i == len - 1));
        i++;
      end
      tick();
      step++;
    end
    chk({tag, " beat count"}, i, n_beats);
    bus.wr_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    cfg_load = 1'b0;
    cfg_base = '0;
    bus.req_ready = 1'b1;
    bus.wr_ready = 1'b1;
    drive_fifo();
    #1;
    chk("rst busy", busy, 0);
    chk("rst req_valid", bus.req_valid, 0);
    chk("rst wr_valid", bus.wr_valid, 0);
    chk("rst wr_last", bus.wr_last, 0);
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst req_addr", bus.req_addr, 0);
    chk("rst req_len", bus.req_len, 0);
    chk("rst state", state_dbg, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // full burst from loaded base
    cfg_base = 32'h100;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hA000_0000 + 32'(i));
    wait_req(32'h100, 4, "s1");
    tick();
    chk("s1 state DATA", state_dbg, 2);
    collect(4, 4, 32'hA000_0000, 1'b0, "s1");
    chk("s1 idle after last", busy, 0);

    // partial burst forced by the idle timer
    push(32'hB000_0000);
    push(32'hB000_0001);
    repeat (15) tick();
    chk("s2 before timeout", bus.req_valid, 0);
    tick();
    chk("s2 at timeout", bus.req_valid, 1);
    wait_req(32'h110, 2, "s2");
    tick();
    collect(2, 2, 32'hB000_0000, 1'b0, "s2");

    // flush sends a single beat without waiting
    push(32'hC000_0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("s3 flush immediate", bus.req_valid, 1);
    wait_req(32'h118, 1, "s3");
    tick();
    collect(1, 1, 32'hC000_0000, 1'b0, "s3");

    // flush on an empty FIFO is held until data shows up
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    chk("s3b no req while empty", bus.req_valid, 0);
    push(32'hD000_0000);
    tick();
    chk("s3b pending flush", bus.req_valid, 1);
    wait_req(32'h11C, 1, "s3b");
    tick();
    collect(1, 1, 32'hD000_0000, 1'b0, "s3b");

    // request back-pressure, then a stuttering write channel
    bus.req_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hE000_0000 + 32'(i));
    wait_req(32'h120, 4, "s4");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("s4 hold req_valid", bus.req_valid, 1);
      chk("s4 hold req_addr", bus.req_addr, 32'h120);
      chk("s4 hold req_len", bus.req_len, 4);
      chk("s4 hold in_ready", bus.in_ready, 0);
      chk("s4 hold wr_valid", bus.wr_valid, 0);
    end
    bus.req_ready = 1'b1;
    tick();
    collect(4, 4, 32'hE000_0000, 1'b1, "s4");

    // address wrap at the top of the space
    cfg_base = 32'hFFFF_FFF8;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hF000_0000 + 32'(i));
    wait_req(32'hFFFF_FFF8, 4, "s5");
    tick();
    collect(4, 4, 32'hF000_0000, 1'b0, "s5");
    push(32'h6000_0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_req(32'h0000_0008, 1, "s5 wrap");
    tick();
    collect(1, 1, 32'h6000_0000, 1'b0, "s5 wrap");

    // reset in the middle of a burst
    for (int i = 0; i < 4; i++) push(32'h7000_0000 + 32'(i));
    wait_req(32'h0000_000C, 4, "s6");
    tick();
    collect(2, 4, 32'h7000_0000, 1'b0, "s6");
    chk("s6 beat 2 pending", bus.wr_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("s6 rst busy", busy, 0);
    chk("s6 rst wr_valid", bus.wr_valid, 0);
    chk("s6 rst in_ready", bus.in_ready, 0);
    chk("s6 rst wr_last", bus.wr_last, 0);
    chk("s6 rst req_valid", bus.req_valid, 0);
    chk("s6 rst req_addr", bus.req_addr, 0);
    chk("s6 rst req_len", bus.req_len, 0);
    chk("s6 rst state", state_dbg, 0);
    fifo_q.delete();
    drive_fifo();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) push(32'h8000_0000 + 32'(i));
    wait_req(32'h0, 4, "s6 post-reset");
    tick();
    collect(4, 4, 32'h8000_0000, 1'b0, "s6 post-reset");

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
